rv32i_control_fsm: RTL and testbench

//  Multicycle RV32I control unit, directly upstream of the datapath.

---
 rtl/rv32i_control_fsm.sv | 268 ++++++++++++++++++++++++++
 tb/tb_rv32i_control_fsm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_control_fsm.sv
// Multicycle RV32I control FSM plus the datapath_types package it drives.
// Optional CTRL_TRAP_ILLEGAL_EN: unknown opcodes trap into HALT instead of running as NOPs.
package datapath_types;
  typedef enum logic [1:0] {pcmux_pc_plus4, pcmux_alu_out, pcmux_alu_mod2} pcmux_sel_t;
  typedef enum logic {alumux1_rs1_out, alumux1_pc_out} alumux1_sel_t;
  typedef enum logic [2:0] {alumux2_i_imm, alumux2_u_imm, alumux2_b_imm, alumux2_s_imm,
                            alumux2_j_imm, alumux2_rs2_out} alumux2_sel_t;
  typedef enum logic [3:0] {regfilemux_alu_out, regfilemux_br_en, regfilemux_u_imm,
                            regfilemux_lw, regfilemux_pc_plus4, regfilemux_lb,
                            regfilemux_lbu, regfilemux_lh, regfilemux_lhu} regfilemux_sel_t;
  typedef enum logic {marmux_pc_out, marmux_alu_out} marmux_sel_t;
  typedef enum logic {cmpmux_rs2_out, cmpmux_i_imm} cmpmux_sel_t;
  typedef enum logic [2:0] {alu_add, alu_sll, alu_sra, alu_sub,
                            alu_xor, alu_srl, alu_or, alu_and} alu_ops_t;

  parameter logic [6:0] op_lui   = 7'b0110111;
  parameter logic [6:0] op_auipc = 7'b0010111;
  parameter logic [6:0] op_jal   = 7'b1101111;
  parameter logic [6:0] op_jalr  = 7'b1100111;
  parameter logic [6:0] op_br    = 7'b1100011;
  parameter logic [6:0] op_load  = 7'b0000011;
  parameter logic [6:0] op_store = 7'b0100011;
  parameter logic [6:0] op_imm   = 7'b0010011;
  parameter logic [6:0] op_reg   = 7'b0110011;

  parameter logic [2:0] cmp_blt  = 3'b100;
  parameter logic [2:0] cmp_bltu = 3'b110;

  typedef struct packed {
    logic            load_pc;
    logic            load_ir;
    logic            load_regfile;
    logic            load_mar;
    logic            load_mdr;
    logic            load_data_out;
    pcmux_sel_t      pcmux_sel;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    marmux_sel_t     marmux_sel;
    cmpmux_sel_t     cmpmux_sel;
    alu_ops_t        aluop;
    logic [2:0]      cmpop;
    logic [1:0]      mdr_shift;  // byte offset of the loaded datum inside MDR
  } control_sig;
endpackage

module rv32i_control_fsm
  import datapath_types::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_en,
  input  logic [1:0] addr_lo,
  input  logic       mem_resp,
  output control_sig ctrl,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_byte_enable,
  output logic       mem_timeout,
  output logic       illegal_op
);

  typedef enum logic [4:0] {
    s_fetch1, s_fetch2, s_fetch3, s_decode,
    s_lui, s_auipc, s_jal, s_jalr, s_br, s_imm, s_reg,
    s_calc_ld, s_ld1, s_ld2, s_calc_st, s_st1, s_st2, s_halt
  } state_t;

  state_t      state, state_nx;
  logic [31:0] wait_cnt;
  logic        mem_state, wait_expired, rd_req, wr_req, timeout_q;
  logic        unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
  assign mem_state     = (state == s_fetch2) || (state == s_ld1) || (state == s_st1);
  // wait_cnt holds cycles already spent, so this fires on the MEM_WAIT_MAX-th cycle
  assign wait_expired  = (MEM_WAIT_MAX != 0) && mem_state && !mem_resp &&
                         (wait_cnt == MEM_WAIT_MAX - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= s_fetch1;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (MEM_WAIT_MAX != 0 && mem_state && state_nx == state) ? wait_cnt + 1 : '0;
      if (wait_expired) timeout_q <= 1'b1;
    end
  end

`ifdef CTRL_TRAP_ILLEGAL_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (rst)                                          illegal_q <= 1'b0;
    else if (state == s_decode && state_nx == s_halt) illegal_q <= 1'b1;
  end
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  always_comb begin
    ctrl                = '0;
    ctrl.pcmux_sel      = pcmux_pc_plus4;
    ctrl.alumux1_sel    = alumux1_rs1_out;
    ctrl.alumux2_sel    = alumux2_i_imm;
    ctrl.regfilemux_sel = regfilemux_alu_out;
    ctrl.marmux_sel     = marmux_pc_out;
    ctrl.cmpmux_sel     = cmpmux_rs2_out;
    ctrl.aluop          = alu_add;
    ctrl.cmpop          = funct3;
    rd_req              = 1'b0;
    wr_req              = 1'b0;
    mem_byte_enable     = 4'hF;
    state_nx            = state;

    case (state)
      s_fetch1: begin
        ctrl.load_mar = 1'b1;
        state_nx      = s_fetch2;
      end
      s_fetch2: begin
        rd_req        = 1'b1;
        ctrl.load_mdr = 1'b1;
        if (wait_expired)  state_nx = s_fetch1;
        else if (mem_resp) state_nx = s_fetch3;
      end
      s_fetch3: begin
        ctrl.load_ir = 1'b1;
        state_nx     = s_decode;
      end
      s_decode: begin
        case (opcode)
          op_lui:   state_nx = s_lui;
          op_auipc: state_nx = s_auipc;
          op_jal:   state_nx = s_jal;
          op_jalr:  state_nx = s_jalr;
          op_br:    state_nx = s_br;
          op_imm:   state_nx = s_imm;
          op_reg:   state_nx = s_reg;
          op_load:  state_nx = s_calc_ld;
          op_store: state_nx = s_calc_st;
          default: begin
`ifdef CTRL_TRAP_ILLEGAL_EN
            state_nx = s_halt;
`else
            ctrl.load_pc = 1'b1;
            state_nx     = s_fetch1;
`endif
          end
        endcase
      end
      s_lui: begin
        ctrl.regfilemux_sel = regfilemux_u_imm;
        ctrl.load_regfile   = 1'b1;
        ctrl.load_pc        = 1'b1;
        state_nx            = s_fetch1;
      end
      s_auipc: begin
        ctrl.alumux1_sel  = alumux1_pc_out;
        ctrl.alumux2_sel  = alumux2_u_imm;
        ctrl.load_regfile = 1'b1;
        ctrl.load_pc      = 1'b1;
        state_nx          = s_fetch1;
      end
      s_jal: begin
        ctrl.alumux1_sel    = alumux1_pc_out;
        ctrl.alumux2_sel    = alumux2_j_imm;
        ctrl.pcmux_sel      = pcmux_alu_out;
        ctrl.regfilemux_sel = regfilemux_pc_plus4;
        ctrl.load_regfile   = 1'b1;
        ctrl.load_pc        = 1'b1;
        state_nx            = s_fetch1;
      end
      s_jalr: begin
        ctrl.pcmux_sel      = pcmux_alu_mod2;
        ctrl.regfilemux_sel = regfilemux_pc_plus4;
        ctrl.load_regfile   = 1'b1;
        ctrl.load_pc        = 1'b1;
        state_nx            = s_fetch1;
      end
      s_br: begin
        ctrl.alumux1_sel = alumux1_pc_out;
        ctrl.alumux2_sel = alumux2_b_imm;
        ctrl.pcmux_sel   = br_en ? pcmux_alu_out : pcmux_pc_plus4;
        ctrl.load_pc     = 1'b1;
        state_nx         = s_fetch1;
      end
      s_imm, s_reg: begin
        if (state == s_reg) ctrl.alumux2_sel = alumux2_rs2_out;
        case (funct3)
          3'b000: ctrl.aluop = (state == s_reg && funct7[5]) ? alu_sub : alu_add;
          3'b010, 3'b011: begin
            ctrl.cmpop          = (funct3[0]) ? cmp_bltu : cmp_blt;
            ctrl.cmpmux_sel     = (state == s_imm) ? cmpmux_i_imm : cmpmux_rs2_out;
            ctrl.regfilemux_sel = regfilemux_br_en;
          end
          3'b101:  ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
          default: ctrl.aluop = alu_ops_t'(funct3);
        endcase
        ctrl.load_regfile = 1'b1;
        ctrl.load_pc      = 1'b1;
        state_nx          = s_fetch1;
      end
      s_calc_ld: begin
        ctrl.marmux_sel = marmux_alu_out;
        ctrl.load_mar   = 1'b1;
        state_nx        = s_ld1;
      end
      s_ld1: begin
        rd_req        = 1'b1;
        ctrl.load_mdr = 1'b1;
        if (wait_expired)  state_nx = s_fetch1;
        else if (mem_resp) state_nx = s_ld2;
      end
      s_ld2: begin
        case (funct3)
          3'b000:  ctrl.regfilemux_sel = regfilemux_lb;
          3'b001:  ctrl.regfilemux_sel = regfilemux_lh;
          3'b100:  ctrl.regfilemux_sel = regfilemux_lbu;
          3'b101:  ctrl.regfilemux_sel = regfilemux_lhu;
          default: ctrl.regfilemux_sel = regfilemux_lw;
        endcase
        ctrl.mdr_shift    = addr_lo;
        ctrl.load_regfile = 1'b1;
        ctrl.load_pc      = 1'b1;
        state_nx          = s_fetch1;
      end
      s_calc_st: begin
        ctrl.alumux2_sel   = alumux2_s_imm;
        ctrl.marmux_sel    = marmux_alu_out;
        ctrl.load_mar      = 1'b1;
        ctrl.load_data_out = 1'b1;
        state_nx           = s_st1;
      end
      s_st1: begin
        wr_req = 1'b1;
        // 4-bit shift truncates, so a halfword at offset 3 keeps only byte 3
        case (funct3[1:0])
          2'b00:   mem_byte_enable = 4'b0001 << addr_lo;
          2'b01:   mem_byte_enable = 4'b0011 << addr_lo;
          default: mem_byte_enable = 4'hF;
        endcase
        if (wait_expired)  state_nx = s_fetch1;
        else if (mem_resp) state_nx = s_st2;
      end
      s_st2: begin
        ctrl.load_pc = 1'b1;
        state_nx     = s_fetch1;
      end
      s_halt:  state_nx = s_halt;
      default: state_nx = s_fetch1;
    endcase
  end

  // reset drops an in-flight request immediately rather than at the next edge
  assign mem_read    = rd_req & ~rst;
  assign mem_write   = wr_req & ~rst;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_rv32i_control_fsm.sv
// Directed bench for rv32i_control_fsm (MEM_WAIT_MAX=4); honours CTRL_TRAP_ILLEGAL_EN.
module tb_rv32i_control_fsm;
  import datapath_types::*;

  logic       clk = 1'b0;
  logic       rst, br_en, mem_resp;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [1:0] addr_lo;
  control_sig ctrl;
  logic       mem_read, mem_write, mem_timeout, illegal_op;
  logic [3:0] mem_byte_enable;

  always #5 clk = ~clk;

  rv32i_control_fsm #(.MEM_WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .addr_lo(addr_lo), .mem_resp(mem_resp), .ctrl(ctrl),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_timeout(mem_timeout), .illegal_op(illegal_op)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit at_fetch1();
    return ctrl.load_mar && ctrl.marmux_sel == marmux_pc_out;
  endfunction

  task automatic step(input logic resp);
    mem_resp = resp;
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
  endtask

  int         r_cycles, r_rd, r_wr, r_rf, r_pcl;
  logic [3:0] r_be;
  logic [31:0] r_pcmux, r_alumux2, r_rfmux, r_aluop, r_cmpop, r_shift;

  // Runs one instruction from FETCH1 until FETCH1 comes round again (or max_cyc).
  // The first request is the fetch; later ones are data. A delay of 0 never responds.
  task automatic run_instr(input int fetch_dly, input int data_dly, input int max_cyc);
    int   req_idx = 0;
    int   req_cyc = 0;
    int   dly;
    bit   in_req = 1'b0;
    logic resp;
    r_cycles = max_cyc; r_rd = 0; r_wr = 0; r_rf = 0; r_pcl = 0; r_be = 4'h0;
    r_pcmux = '1; r_alumux2 = '1; r_rfmux = '1; r_aluop = '1; r_cmpop = '1; r_shift = '1;
    for (int c = 0; c < max_cyc; c++) begin
      if (c > 0 && at_fetch1()) begin
        r_cycles = c;
        return;
      end
      resp = 1'b0;
      if (mem_read || mem_write) begin
        if (!in_req) begin
          in_req = 1'b1;
          req_idx++;
          req_cyc = 0;
        end
        req_cyc++;
        if (mem_read) r_rd++;
        if (mem_write) begin
          r_wr++;
          r_be = mem_byte_enable;
        end
        dly  = (req_idx == 1) ? fetch_dly : data_dly;
        resp = (dly != 0 && req_cyc == dly);
        if (resp) in_req = 1'b0;
      end else begin
        in_req = 1'b0;
      end
      if (ctrl.load_regfile) begin
        r_rf++;
        r_rfmux = 32'(ctrl.regfilemux_sel);
        r_aluop = 32'(ctrl.aluop);
        r_cmpop = 32'(ctrl.cmpop);
        r_shift = 32'(ctrl.mdr_shift);
      end
      if (ctrl.load_pc) begin
        r_pcl++;
        r_pcmux   = 32'(ctrl.pcmux_sel);
        r_alumux2 = 32'(ctrl.alumux2_sel);
      end
      step(resp);
    end
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [1:0] lo);
    opcode = op; funct3 = f3; funct7 = f7; addr_lo = lo;
  endtask

  initial begin
    rst = 1'b1; br_en = 1'b0; mem_resp = 1'b0;
    set_ir(op_imm, 3'b000, 7'h00, 2'b00);

    // reset
    step(1'b0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    do_reset();
    chk("rst_load_mar", 32'(ctrl.load_mar), 32'd1);
    chk("rst_marmux", 32'(ctrl.marmux_sel), 32'(marmux_pc_out));
    chk("rst_mem_read_rel", 32'(mem_read), 32'd0);
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_be", 32'(mem_byte_enable), 32'hF);

    // ADDI x1,x0,5, fetch responds on its 3rd cycle
    run_instr(3, 0, 30);
    chk("addi_cycles", r_cycles, 7);
    chk("addi_rd", r_rd, 3);
    chk("addi_rf", r_rf, 1);
    chk("addi_aluop", r_aluop, 32'(alu_add));
    chk("addi_rfmux", r_rfmux, 32'(regfilemux_alu_out));

    // stores
    set_ir(op_store, 3'b000, 7'h00, 2'd2);
    run_instr(1, 2, 30);
    chk("sb2_be", 32'(r_be), 32'b0100);
    chk("sb2_wr", r_wr, 2);
    chk("sb2_cycles", r_cycles, 8);
    chk("sb2_pcl", r_pcl, 1);
    chk("sb2_be_idle", 32'(mem_byte_enable), 32'hF);
    set_ir(op_store, 3'b001, 7'h00, 2'd2);
    run_instr(1, 1, 30);
    chk("sh2_be", 32'(r_be), 32'b1100);
    set_ir(op_store, 3'b001, 7'h00, 2'd3);
    run_instr(1, 1, 30);
    chk("sh3_be", 32'(r_be), 32'b1000);
    set_ir(op_store, 3'b010, 7'h00, 2'd0);
    run_instr(1, 1, 30);
    chk("sw_be", 32'(r_be), 32'hF);

    // branches
    set_ir(op_br, 3'b000, 7'h00, 2'd0);
    br_en = 1'b1;
    run_instr(1, 0, 30);
    chk("beq_t_pcmux", r_pcmux, 32'(pcmux_alu_out));
    chk("beq_t_pcl", r_pcl, 1);
    chk("beq_t_alumux2", r_alumux2, 32'(alumux2_b_imm));
    br_en = 1'b0;
    run_instr(1, 0, 30);
    chk("beq_nt_pcmux", r_pcmux, 32'(pcmux_pc_plus4));
    chk("beq_nt_pcl", r_pcl, 1);
    chk("beq_nt_cycles", r_cycles, 5);

    // ALU op selection
    set_ir(op_reg, 3'b000, 7'b0100000, 2'd0);
    run_instr(1, 0, 30);
    chk("sub_aluop", r_aluop, 32'(alu_sub));
    set_ir(op_reg, 3'b010, 7'h00, 2'd0);
    run_instr(1, 0, 30);
    chk("slt_rfmux", r_rfmux, 32'(regfilemux_br_en));
    chk("slt_cmpop", r_cmpop, 32'(3'b100));
    set_ir(op_imm, 3'b101, 7'b0100000, 2'd0);
    run_instr(1, 0, 30);
    chk("srai_aluop", r_aluop, 32'(alu_sra));

    // LB from byte 3
    set_ir(op_load, 3'b000, 7'h00, 2'd3);
    run_instr(1, 2, 30);
    chk("lb_rfmux", r_rfmux, 32'(regfilemux_lb));
    chk("lb_shift", r_shift, 32'd3);
    chk("lb_rf", r_rf, 1);
    chk("lb_cycles", r_cycles, 8);

    // load never answered: four cycles of mem_read, then back to FETCH1
    chk("pre_timeout", 32'(mem_timeout), 32'd0);
    set_ir(op_load, 3'b010, 7'h00, 2'd0);
    run_instr(1, 0, 30);
    chk("to_cycles", r_cycles, 9);
    chk("to_rd", r_rd, 5);
    chk("to_rf", r_rf, 0);
    chk("to_pcl", r_pcl, 0);
    chk("to_flag", 32'(mem_timeout), 32'd1);
    chk("to_mem_read", 32'(mem_read), 32'd0);

    // reset while a fetch is outstanding
    do_reset();
    chk("to_cleared", 32'(mem_timeout), 32'd0);
    step(1'b0);
    chk("midrst_req", 32'(mem_read), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_drop", 32'(mem_read), 32'd0);
    step(1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_fetch1", 32'(at_fetch1()), 32'd1);

    // unknown opcode
    set_ir(7'h7F, 3'b000, 7'h00, 2'd0);
`ifdef CTRL_TRAP_ILLEGAL_EN
    run_instr(1, 0, 12);
    chk("ill_halt", r_cycles, 12);
    chk("ill_flag", 32'(illegal_op), 32'd1);
    chk("ill_pcl", r_pcl, 0);
    chk("ill_mem_read", 32'(mem_read), 32'd0);
    do_reset();
    chk("ill_rst_flag", 32'(illegal_op), 32'd0);
    chk("ill_rst_fetch1", 32'(at_fetch1()), 32'd1);
`else
    run_instr(1, 0, 30);
    chk("nop_cycles", r_cycles, 4);
    chk("nop_pcl", r_pcl, 1);
    chk("nop_pcmux", r_pcmux, 32'(pcmux_pc_plus4));
    chk("nop_flag", 32'(illegal_op), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
